fast_command_scheduler: RTL and testbench

Generates the serial fast-command stream that feeds the fast-control fanout on `fast_clock_in`. The stream is built from fixed-length frames, shifted MSB-first, one bit per clock. The block shares the stream between NREQ requesters: index 0 has strict priority, and the rest are served round-robin. It also auto-inserts a bunch-crossing-reset (BCR) frame at each orbit wrap, and emits an IDLE frame whenever nothing is granted.

---
 rtl/fast_cmd_pkg.sv | 11 +
 rtl/fast_command_scheduler_rr.sv | 62 ++++++
 rtl/fast_command_scheduler.sv | 126 ++++++++++++
 tb/tb_fast_command_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fast_cmd_pkg.sv
// Shared constants and types for the fast-command scheduler.
package fast_cmd_pkg;

    localparam int FC_FRAME_BITS = 8;

    localparam logic [FC_FRAME_BITS-1:0] FC_IDLE_CODE = 8'hAC;
    localparam logic [FC_FRAME_BITS-1:0] FC_BCR_CODE  = 8'h2D;

    typedef logic [FC_FRAME_BITS-1:0] fc_code_t;

endpackage

// File: rtl/fast_command_scheduler_rr.sv
// Round-robin arbiter: combinational one-hot grant, registered search pointer.
// The pointer never drops below PTR_MIN, so index 0 can be kept out of the
// rotation by the caller and arbitrated separately.
module fc_rr_arbiter
    import fast_cmd_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int PTR_MIN = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NREQ-1:0] req_i,
    input  logic            adv_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            valid_o
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    int               hi_sel;
    int               lo_sel;
    logic             hi_hit;
    logic             lo_hit;
    int               sel;

    // Pick the lowest request at or above the pointer, else the lowest overall.
    always_comb begin
        hi_sel = 0;
        lo_sel = 0;
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                lo_sel = i;
                lo_hit = 1'b1;
                if (i >= int'(ptr_q)) begin
                    hi_sel = i;
                    hi_hit = 1'b1;
                end
            end
        end
        sel     = hi_hit ? hi_sel : lo_sel;
        valid_o = lo_hit;
        gnt_o   = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_o[i] = lo_hit && (sel == i);
        end
        ptr_d = (sel >= NREQ - 1) ? PTR_W'(PTR_MIN) : PTR_W'(sel + 1);
    end

    // Move the pointer just past the winner whenever a grant is consumed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= PTR_W'(PTR_MIN);
        end else if (adv_i && valid_o) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fast_command_scheduler.sv
// Serial fast-command frame generator: strict priority for requester 0,
// round-robin for the rest, BCR insertion at orbit wrap, IDLE otherwise.
module fast_command_scheduler
    import fast_cmd_pkg::*;
#(
    parameter int                    NREQ         = 4,
    parameter int                    FRAME_BITS   = FC_FRAME_BITS,
    parameter logic [FRAME_BITS-1:0] IDLE_CODE    = FC_IDLE_CODE,
    parameter logic [FRAME_BITS-1:0] BCR_CODE     = FC_BCR_CODE,
    parameter int                    ORBIT_FRAMES = 3564
) (
    input  logic                            fast_clock_in,
    input  logic                            arstn,
    input  logic                            enable,
    input  logic                            bcr_enable,
    input  logic [NREQ-1:0]                 req,
    input  logic [NREQ*FRAME_BITS-1:0]      req_code,
    output logic [NREQ-1:0]                 ack,
    output logic                            fast_command_serial,
    output logic                            frame_start,
    output logic                            bcr_pulse,
    output logic [$clog2(ORBIT_FRAMES)-1:0] frame_count
);

    localparam int CNT_W = $clog2(FRAME_BITS);
    localparam int FC_W  = $clog2(ORBIT_FRAMES);

    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(FRAME_BITS - 1);
    localparam logic [FC_W-1:0]  LAST_FRAME = FC_W'(ORBIT_FRAMES - 1);

    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [FC_W-1:0]       fc_q, fc_d, fc_next;
    logic [NREQ-1:0]       ack_q, ack_d;
    logic                  bcr_q, bcr_d;
    logic                  boundary;
    logic [NREQ-1:0]       rr_gnt;
    logic                  rr_valid;
    logic                  rr_adv;
    logic [FRAME_BITS-1:0] rr_code;

    assign boundary = (bit_cnt_q == LAST_BIT);
    assign fc_next  = (fc_q == LAST_FRAME) ? '0 : fc_q + FC_W'(1);

    generate
        if (NREQ > 1) begin : g_rr
            fc_rr_arbiter #(
                .NREQ    (NREQ),
                .PTR_MIN (1)
            ) u_rr (
                .clk_i   (fast_clock_in),
                .rst_ni  (arstn),
                .req_i   (req & ~NREQ'(1)),
                .adv_i   (rr_adv),
                .gnt_o   (rr_gnt),
                .valid_o (rr_valid)
            );
        end else begin : g_no_rr
            assign rr_gnt   = '0;
            assign rr_valid = 1'b0;
        end
    endgenerate

    // Select the command code of the round-robin winner.
    always_comb begin
        rr_code = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (rr_gnt[i]) begin
                rr_code = req_code[i*FRAME_BITS +: FRAME_BITS];
            end
        end
    end

    // Shift mid-frame; at the last bit choose and load the next frame.
    always_comb begin
        shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        fc_d      = fc_q;
        ack_d     = '0;
        bcr_d     = 1'b0;
        rr_adv    = 1'b0;
        if (boundary) begin
            bit_cnt_d = '0;
            fc_d      = fc_next;
            if (bcr_enable && (fc_next == '0)) begin
                shreg_d = BCR_CODE;
                bcr_d   = 1'b1;
            end else if (!enable) begin
                shreg_d = IDLE_CODE;
            end else if (req[0]) begin
                shreg_d  = req_code[FRAME_BITS-1:0];
                ack_d[0] = 1'b1;
            end else if (rr_valid) begin
                shreg_d = rr_code;
                ack_d   = rr_gnt;
                rr_adv  = 1'b1;
            end else begin
                shreg_d = IDLE_CODE;
            end
        end
    end

    // State registers; reset leaves an IDLE frame already on the wire.
    always_ff @(posedge fast_clock_in or negedge arstn) begin
        if (!arstn) begin
            shreg_q   <= IDLE_CODE;
            bit_cnt_q <= '0;
            fc_q      <= '0;
            ack_q     <= '0;
            bcr_q     <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            fc_q      <= fc_d;
            ack_q     <= ack_d;
            bcr_q     <= bcr_d;
        end
    end

    assign fast_command_serial = shreg_q[FRAME_BITS-1];
    assign frame_start         = (bit_cnt_q == '0);
    assign ack                 = ack_q;
    assign bcr_pulse           = bcr_q;
    assign frame_count         = fc_q;

endmodule

// File: tb/tb_fast_command_scheduler.sv
// Directed bench for fast_command_scheduler (NREQ=4, 8-bit frames, 4-frame orbit).
module tb_fast_command_scheduler;
    import fast_cmd_pkg::*;

    localparam int NREQ  = 4;
    localparam int FB    = 8;
    localparam int ORBIT = 4;

    localparam fc_code_t IDLE  = 8'hAC;
    localparam fc_code_t BCR   = 8'h2D;
    localparam fc_code_t CODE0 = 8'hE1;
    localparam fc_code_t CODE1 = 8'h96;
    localparam fc_code_t CODE2 = 8'h5A;
    localparam fc_code_t CODE3 = 8'h3C;

    logic            fast_clock_in = 1'b0;
    logic            arstn         = 1'b1;
    logic            enable        = 1'b1;
    logic            bcr_enable    = 1'b0;
    logic [NREQ-1:0] req           = '0;
    logic [NREQ*FB-1:0] req_code;
    logic [NREQ-1:0] ack;
    logic            fast_command_serial;
    logic            frame_start;
    logic            bcr_pulse;
    logic [1:0]      frame_count;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    always #5 fast_clock_in = ~fast_clock_in;

    fast_command_scheduler #(
        .NREQ         (NREQ),
        .FRAME_BITS   (FB),
        .IDLE_CODE    (IDLE),
        .BCR_CODE     (BCR),
        .ORBIT_FRAMES (ORBIT)
    ) dut (
        .fast_clock_in       (fast_clock_in),
        .arstn               (arstn),
        .enable              (enable),
        .bcr_enable          (bcr_enable),
        .req                 (req),
        .req_code            (req_code),
        .ack                 (ack),
        .fast_command_serial (fast_command_serial),
        .frame_start         (frame_start),
        .bcr_pulse           (bcr_pulse),
        .frame_count         (frame_count)
    );

    task automatic tick();
        @(posedge fast_clock_in);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        arstn = 1'b1;
        #1 arstn = 1'b0;
        #2;
        vectors++;
        if (fast_command_serial !== 1'b1) begin errors++; $display("FAIL rst_serial got=%b want=1", fast_command_serial); end
        vectors++;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL rst_frame_start got=%b want=1", frame_start); end
        vectors++;
        if (ack !== 4'b0000) begin errors++; $display("FAIL rst_ack got=%b want=0000", ack); end
        vectors++;
        if (bcr_pulse !== 1'b0) begin errors++; $display("FAIL rst_bcr got=%b want=0", bcr_pulse); end
        vectors++;
        if (frame_count !== 2'd0) begin errors++; $display("FAIL rst_fc got=%0d want=0", frame_count); end
        #19 arstn = 1'b1;
        cyc = 0;
    endtask

    task automatic test_idle();
        fc_code_t code;
        code = IDLE;
        for (int i = 0; i < 3 * FB; i++) begin
            vectors++;
            if (fast_command_serial !== code[FB-1-(cyc%FB)]) begin errors++; $display("FAIL idle_serial cyc=%0d got=%b want=%b", cyc, fast_command_serial, code[FB-1-(cyc%FB)]); end
            vectors++;
            if (frame_start !== (cyc % FB == 0)) begin errors++; $display("FAIL idle_fs cyc=%0d got=%b want=%b", cyc, frame_start, (cyc % FB == 0)); end
            vectors++;
            if (ack !== 4'b0000) begin errors++; $display("FAIL idle_ack cyc=%0d got=%b want=0000", cyc, ack); end
            vectors++;
            if (frame_count !== 2'((cyc / FB) % ORBIT)) begin errors++; $display("FAIL idle_fc cyc=%0d got=%0d want=%0d", cyc, frame_count, (cyc / FB) % ORBIT); end
            tick();
        end
    endtask

    task automatic test_single_grant();
        fc_code_t code;
        req = 4'b0100;
        repeat (FB) tick();
        for (int f = 0; f < 2; f++) begin
            code = (f == 0) ? CODE2 : IDLE;
            for (int b = 0; b < FB; b++) begin
                vectors++;
                if (fast_command_serial !== code[FB-1-b]) begin errors++; $display("FAIL single_serial f=%0d b=%0d got=%b want=%b", f, b, fast_command_serial, code[FB-1-b]); end
                vectors++;
                if (ack !== ((f == 0 && b == 0) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL single_ack f=%0d b=%0d got=%b", f, b, ack); end
                if (b == 0) begin
                    vectors++;
                    if (frame_count !== 2'((cyc / FB) % ORBIT)) begin errors++; $display("FAIL single_fc got=%0d want=%0d", frame_count, (cyc / FB) % ORBIT); end
                    req = 4'b0000;
                end
                tick();
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ack [6];
        fc_code_t   exp_code[6];
        exp_ack  = '{4'b1000, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        exp_code = '{CODE3, CODE1, CODE3, CODE0, CODE1, CODE3};
        req = 4'b1010;
        repeat (FB) tick();
        for (int f = 0; f < 6; f++) begin
            for (int b = 0; b < FB; b++) begin
                vectors++;
                if (fast_command_serial !== exp_code[f][FB-1-b]) begin errors++; $display("FAIL rr_serial f=%0d b=%0d got=%b want=%b", f, b, fast_command_serial, exp_code[f][FB-1-b]); end
                vectors++;
                if (ack !== ((b == 0) ? exp_ack[f] : 4'b0000)) begin errors++; $display("FAIL rr_ack f=%0d b=%0d got=%b want=%b", f, b, ack, (b == 0) ? exp_ack[f] : 4'b0000); end
                if (b == 0) begin
                    if (f == 2) req = 4'b1011;
                    if (f == 3) req = 4'b1010;
                    if (f == 5) req = 4'b0000;
                end
                tick();
            end
        end
    endtask

    task automatic test_bcr();
        fc_code_t   code;
        logic       is_bcr;
        logic [1:0] efc;
        bcr_enable = 1'b1;
        req        = 4'b0010;
        repeat (FB) tick();
        for (int f = 0; f < 8; f++) begin
            efc    = 2'((cyc / FB) % ORBIT);
            is_bcr = (efc == 2'd0);
            code   = is_bcr ? BCR : CODE1;
            vectors++;
            if (frame_count !== efc) begin errors++; $display("FAIL bcr_fc f=%0d got=%0d want=%0d", f, frame_count, efc); end
            for (int b = 0; b < FB; b++) begin
                vectors++;
                if (fast_command_serial !== code[FB-1-b]) begin errors++; $display("FAIL bcr_serial f=%0d b=%0d got=%b want=%b", f, b, fast_command_serial, code[FB-1-b]); end
                vectors++;
                if (ack !== ((b == 0 && !is_bcr) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL bcr_ack f=%0d b=%0d got=%b", f, b, ack); end
                vectors++;
                if (bcr_pulse !== (b == 0 && is_bcr)) begin errors++; $display("FAIL bcr_pulse f=%0d b=%0d got=%b want=%b", f, b, bcr_pulse, (b == 0 && is_bcr)); end
                if (b == 0 && f == 7) begin
                    req        = 4'b0000;
                    bcr_enable = 1'b0;
                end
                tick();
            end
        end
    endtask

    task automatic test_enable();
        fc_code_t code;
        enable = 1'b0;
        req    = 4'b0100;
        repeat (FB) tick();
        for (int f = 0; f < 4; f++) begin
            code = (f == 3) ? CODE2 : IDLE;
            for (int b = 0; b < FB; b++) begin
                vectors++;
                if (fast_command_serial !== code[FB-1-b]) begin errors++; $display("FAIL en_serial f=%0d b=%0d got=%b want=%b", f, b, fast_command_serial, code[FB-1-b]); end
                vectors++;
                if (ack !== ((f == 3 && b == 0) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL en_ack f=%0d b=%0d got=%b", f, b, ack); end
                if (f == 2 && b == 3) enable = 1'b1;
                if (f == 3 && b == 0) req = 4'b0000;
                tick();
            end
        end
    endtask

    task automatic test_withdraw();
        fc_code_t code;
        code = IDLE;
        req  = 4'b1000;
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < FB; b++) begin
                vectors++;
                if (fast_command_serial !== code[FB-1-b]) begin errors++; $display("FAIL wd_serial f=%0d b=%0d got=%b want=%b", f, b, fast_command_serial, code[FB-1-b]); end
                vectors++;
                if (ack !== 4'b0000) begin errors++; $display("FAIL wd_ack f=%0d b=%0d got=%b want=0000", f, b, ack); end
                if (f == 0 && b == 4) req = 4'b0000;
                tick();
            end
        end
    endtask

    task automatic test_async_reset();
        fc_code_t code;
        req = 4'b0001;
        repeat (FB) tick();
        vectors++;
        if (ack !== 4'b0001) begin errors++; $display("FAIL ar_pre_ack got=%b want=0001", ack); end
        req = 4'b0010;
        repeat (3) tick();
        vectors++;
        if (fast_command_serial !== 1'b0) begin errors++; $display("FAIL ar_pre_serial got=%b want=0", fast_command_serial); end
        #2 arstn = 1'b0;
        #1;
        vectors++;
        if (fast_command_serial !== 1'b1) begin errors++; $display("FAIL ar_serial got=%b want=1", fast_command_serial); end
        vectors++;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL ar_fs got=%b want=1", frame_start); end
        vectors++;
        if (frame_count !== 2'd0) begin errors++; $display("FAIL ar_fc got=%0d want=0", frame_count); end
        vectors++;
        if (ack !== 4'b0000) begin errors++; $display("FAIL ar_ack got=%b want=0000", ack); end
        @(negedge fast_clock_in);
        #2 arstn = 1'b1;
        cyc = 0;
        for (int f = 0; f < 2; f++) begin
            code = (f == 0) ? IDLE : CODE1;
            vectors++;
            if (frame_count !== 2'(f)) begin errors++; $display("FAIL ar_post_fc f=%0d got=%0d want=%0d", f, frame_count, f); end
            for (int b = 0; b < FB; b++) begin
                vectors++;
                if (fast_command_serial !== code[FB-1-b]) begin errors++; $display("FAIL ar_post_serial f=%0d b=%0d got=%b want=%b", f, b, fast_command_serial, code[FB-1-b]); end
                vectors++;
                if (ack !== ((f == 1 && b == 0) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL ar_post_ack f=%0d b=%0d got=%b", f, b, ack); end
                if (f == 1 && b == 0) req = 4'b0000;
                tick();
            end
        end
    endtask

    initial begin
        req_code = {CODE3, CODE2, CODE1, CODE0};
        test_reset();
        test_idle();
        test_single_grant();
        test_round_robin();
        test_bcr();
        test_enable();
        test_withdraw();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
